// File: rtl/datapath_pipereg_pkg.sv
// -----------------------------------------------------------------------------
// datapath_pipereg_pkg
//
// Purpose:
//   Shared definitions for the elastic pipeline register. The occupancy
//   counter of the top level is driven from a small decode of the three
//   events that can touch it in a cycle (flush, input transfer, output
//   transfer). Keeping that decode in one function makes the priority
//   explicit: flush wins, and simultaneous in/out transfers cancel.
//
// Contents:
//   count_op_e  - operation applied to the occupancy counter this cycle
//   count_op()  - priority decode of flush / input / output transfer
// -----------------------------------------------------------------------------
package datapath_pipereg_pkg;

    // Operation applied to the occupancy counter at the next clock edge.
    typedef enum logic [1:0] {
        CNT_HOLD = 2'd0,
        CNT_INC  = 2'd1,
        CNT_DEC  = 2'd2,
        CNT_CLR  = 2'd3
    } count_op_e;

    // Flush clears the counter regardless of any handshake; a transfer on
    // both ends in the same cycle leaves the occupancy unchanged.
    function automatic count_op_e count_op(
        input logic clr,
        input logic in_xfer,
        input logic out_xfer
    );
        count_op_e op;
        if (clr) begin
            op = CNT_CLR;
        end else if (in_xfer && !out_xfer) begin
            op = CNT_INC;
        end else if (out_xfer && !in_xfer) begin
            op = CNT_DEC;
        end else begin
            op = CNT_HOLD;
        end
        return op;
    endfunction

endpackage : datapath_pipereg_pkg

// File: rtl/datapath_pipe_stage.sv
// -----------------------------------------------------------------------------
// datapath_pipe_stage
//
// Purpose:
//   One stage of the elastic pipeline register. The stage is a load register
//   whose load enable is its own handshake: it captures up_data whenever it
//   can accept and the upstream side offers a word. The data register changes
//   only on such a load, so a held word is never overwritten while it is
//   stalled.
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   synchronous active-low reset (clears valid and data)
//   flush     in   synchronous clear of the valid bit; data is retained
//   up_valid  in   upstream offers up_data this cycle
//   up_data   in   upstream data (WIDTH bits)
//   dn_ready  in   downstream accepts this stage's word this cycle
//   acc       out  stage can take a new word this cycle (combinational)
//   vld       out  stage holds a valid word (registered)
//   dat       out  stage data (registered)
// -----------------------------------------------------------------------------
module datapath_pipe_stage #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    input  logic             dn_ready,
    output logic             acc,
    output logic             vld,
    output logic [WIDTH-1:0] dat
);

    // Power-up values equal the reset values.
    logic             vld_r = 1'b0;
    logic [WIDTH-1:0] dat_r = {WIDTH{1'b0}};
    logic             adv_s;
    logic             load_s;

    // The word leaves this stage when it is valid and downstream takes it.
    assign adv_s = vld_r & dn_ready;

    // An empty stage, or one that is emptying this cycle, can take a word.
    // This is the term that chains the ready path back through all stages.
    assign acc = ~vld_r | adv_s;

    // Flush must also stop inner stages from shifting, so dat[] is retained.
    assign load_s = acc & up_valid & ~flush;

    // Stage register: data moves only on load; valid follows load/advance/flush.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_r <= 1'b0;
            dat_r <= {WIDTH{1'b0}};
        end else if (flush) begin
            vld_r <= 1'b0;
        end else if (load_s) begin
            vld_r <= 1'b1;
            dat_r <= up_data;
        end else if (adv_s) begin
            vld_r <= 1'b0;
        end else begin
            vld_r <= vld_r;
        end
    end

    assign vld = vld_r;
    assign dat = dat_r;

endmodule : datapath_pipe_stage

// File: rtl/datapath_pipereg.sv
// -----------------------------------------------------------------------------
// datapath_pipereg
//
// Purpose:
//   Elastic DEPTH-stage pipeline register with valid/ready handshakes on both
//   ends. Stalls propagate back combinationally (out_ready -> in_ready), holes
//   between stages collapse while the tail stalls, and a synchronous flush
//   empties every stage in one cycle. The last stage drives out_valid and
//   out_data directly, so both are register outputs. An occupancy counter
//   reports how many stages currently hold a word.
//
// Parameters:
//   WIDTH  data width in bits (>= 1)
//   DEPTH  number of register stages (>= 1)
//   CW     occupancy counter width, derived from DEPTH
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset
//   flush      in   synchronous clear of all stage valid bits
//   in_valid   in   producer offers in_data this cycle
//   in_data    in   producer data
//   in_ready   out  pipeline accepts in_data this cycle
//   out_valid  out  last stage holds valid data
//   out_data   out  last-stage data
//   out_ready  in   consumer takes out_data this cycle
//   count      out  number of valid stages, 0..DEPTH
// -----------------------------------------------------------------------------
module datapath_pipereg
    import datapath_pipereg_pkg::*;
#(
    parameter  int WIDTH = 10,
    parameter  int DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [CW-1:0]    count
);

    logic          in_xfer_s;
    logic          out_xfer_s;
    // Power-up value equals the reset value.
    logic [CW-1:0] count_r = {CW{1'b0}};

    // Each stage keeps its handshake signals local to its generate block so
    // the acc chain is a series of distinct nets rather than one vector that
    // feeds back on itself.
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             up_valid_s;
        logic [WIDTH-1:0] up_data_s;
        logic             dn_ready_s;
        logic             acc_s;
        logic             vld_s;
        logic [WIDTH-1:0] dat_s;

        if (i == 0) begin : g_head
            // The head stage only sees a word the producer actually transfers.
            assign up_valid_s = in_valid & in_ready;
            assign up_data_s  = in_data;
        end else begin : g_body
            assign up_valid_s = g_stage[i-1].vld_s;
            assign up_data_s  = g_stage[i-1].dat_s;
        end

        if (i == DEPTH - 1) begin : g_tail
            assign dn_ready_s = out_ready;
        end else begin : g_inner
            assign dn_ready_s = g_stage[i+1].acc_s;
        end

        datapath_pipe_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .flush    (flush),
            .up_valid (up_valid_s),
            .up_data  (up_data_s),
            .dn_ready (dn_ready_s),
            .acc      (acc_s),
            .vld      (vld_s),
            .dat      (dat_s)
        );
    end

    // Input is refused during flush so the word offered that cycle is dropped
    // cleanly rather than half-captured.
    assign in_ready  = g_stage[0].acc_s & ~flush;
    assign out_valid = g_stage[DEPTH-1].vld_s;
    assign out_data  = g_stage[DEPTH-1].dat_s;

    assign in_xfer_s  = in_valid & in_ready;
    assign out_xfer_s = out_valid & out_ready;

    // Occupancy counter: tracks the number of set stage valid bits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_r <= {CW{1'b0}};
        end else begin
            case (count_op(flush, in_xfer_s, out_xfer_s))
                CNT_CLR:  count_r <= {CW{1'b0}};
                CNT_INC:  count_r <= count_r + CW'(1'b1);
                CNT_DEC:  count_r <= count_r - CW'(1'b1);
                CNT_HOLD: count_r <= count_r;
                default:  count_r <= count_r;
            endcase
        end
    end

    assign count = count_r;

endmodule : datapath_pipereg
